// File: rtl/uart_msg_fifo_if.sv
// rtl/uart_msg_fifo_if.sv - write/read/status bundle between the UART receive path and the message FIFO
interface uart_msg_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [CW-1:0]         msg_count;
    logic                  msg_ready;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, overflow, msg_count, msg_ready
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, overflow, msg_count, msg_ready
    );
endinterface

// File: rtl/uart_msg_fifo.sv
// rtl/uart_msg_fifo.sv - byte FIFO that counts stored TERMINATOR words so a whole message can be consumed at once
module uart_msg_fifo #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] TERMINATOR = DATA_WIDTH'(8'h0D)
) (
    input  logic              clk,
    input  logic              rst,
    uart_msg_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_msg_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_drop;
    logic                  w_wr_term;
    logic                  w_rd_term;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         w_msg_nxt;

    // Assertion reaches the state instantly; release is retimed to clk by two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_rd_word = r_mem[r_rd_ptr];

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_wr_acc  = bus.wr_en && !bus.clear && (!w_full || bus.rd_en);
    assign w_rd_acc  = bus.rd_en && !bus.clear && !w_empty;
    assign w_drop    = bus.wr_en && !bus.clear && w_full && !bus.rd_en;
    assign w_wr_term = w_wr_acc && (bus.wr_data == TERMINATOR);
    assign w_rd_term = w_rd_acc && (w_rd_word == TERMINATOR);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CW'(1);
        else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - CW'(1);
    end

    always_comb begin
        w_msg_nxt = r_msg_count;
        if (w_wr_term && !w_rd_term)      w_msg_nxt = r_msg_count + CW'(1);
        else if (!w_wr_term && w_rd_term) w_msg_nxt = r_msg_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_msg_count <= '0;
            r_overflow  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_msg_count <= '0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_count     <= w_count_nxt;
            r_msg_count <= w_msg_nxt;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_drop)   r_overflow <= 1'b1;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.msg_count = r_msg_count;
    assign bus.msg_ready = (r_msg_count != '0);
endmodule
